// File: rtl/healthcare_system_first_phase.sv
// rtl/healthcare_system_first_phase.sv - first-phase vital-sign evaluator with registered indicators
module healthcare_system_first_phase (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] pressureData,
    input  logic [3:0] bloodPH,
    input  logic [2:0] bloodType,
    input  logic [7:0] fdSensorValue,
    input  logic [7:0] fdFactoryValue,
    input  logic [7:0] bloodSensor,
    input  logic [7:0] factoryBaseTemp,
    input  logic [3:0] factoryTempCoef,
    input  logic [3:0] tempSensorValue,
    output logic       presureAbnormality,
    output logic       bloodAbnormality,
    output logic       fallDetected,
    output logic [3:0] glycemicIndex,
    output logic       temperatureAbnormality
);

    logic       presureNext;
    logic       bloodNext;
    logic       fallNext;
    logic [3:0] glycemicNext;
    logic       temperatureNext;

    logic [3:0] sensorOnes;
    logic [3:0] phLow;
    logic [3:0] phHigh;
    logic [7:0] tempProduct;
    logic [8:0] tempSum;

    // Pressure alarm is simply the sensor code MSB; fall is an unsigned >= compare.
    always_comb begin
        presureNext = pressureData[5];
        fallNext    = (fdSensorValue >= fdFactoryValue);
    end

    // Blood types 4..7 have their normal pH window shifted down by one.
    always_comb begin
        phLow     = bloodType[2] ? 4'd6 : 4'd7;
        phHigh    = bloodType[2] ? 4'd8 : 4'd9;
        bloodNext = (bloodPH < phLow) || (bloodPH > phHigh);
    end

    // Glycemic index falls with the number of set glucose sensor bits, floored at zero.
    always_comb begin
        sensorOnes = 4'd0;
        for (int i = 0; i < 8; i++) begin
            sensorOnes = sensorOnes + {3'd0, bloodSensor[i]};
        end
        glycemicNext = (sensorOnes >= 4'd7) ? 4'd0 : (4'd7 - sensorOnes);
    end

    // Calibrated temperature kept at 9 bits so the largest sum (480) never wraps.
    always_comb begin
        tempProduct     = {4'd0, factoryTempCoef} * {4'd0, tempSensorValue};
        tempSum         = {1'b0, factoryBaseTemp} + {1'b0, tempProduct};
        temperatureNext = (tempSum < 9'd40) || (tempSum > 9'd45);
    end

    // Output registers: cleared asynchronously, otherwise load every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presureAbnormality     <= 1'b0;
            bloodAbnormality       <= 1'b0;
            fallDetected           <= 1'b0;
            glycemicIndex          <= 4'd0;
            temperatureAbnormality <= 1'b0;
        end else begin
            presureAbnormality     <= presureNext;
            bloodAbnormality       <= bloodNext;
            fallDetected           <= fallNext;
            glycemicIndex          <= glycemicNext;
            temperatureAbnormality <= temperatureNext;
        end
    end

endmodule

// File: tb/tb_healthcare_system_first_phase.sv
// tb/tb_healthcare_system_first_phase.sv - scoreboard bench for healthcare_system_first_phase
module tb_healthcare_system_first_phase;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] pressureData = '0;
    logic [3:0] bloodPH = '0;
    logic [2:0] bloodType = '0;
    logic [7:0] fdSensorValue = '0;
    logic [7:0] fdFactoryValue = '0;
    logic [7:0] bloodSensor = '0;
    logic [7:0] factoryBaseTemp = '0;
    logic [3:0] factoryTempCoef = '0;
    logic [3:0] tempSensorValue = '0;
    logic       presureAbnormality;
    logic       bloodAbnormality;
    logic       fallDetected;
    logic [3:0] glycemicIndex;
    logic       temperatureAbnormality;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   failures = 0;

    healthcare_system_first_phase dut (
        .clk(clk),
        .rst(rst),
        .pressureData(pressureData),
        .bloodPH(bloodPH),
        .bloodType(bloodType),
        .fdSensorValue(fdSensorValue),
        .fdFactoryValue(fdFactoryValue),
        .bloodSensor(bloodSensor),
        .factoryBaseTemp(factoryBaseTemp),
        .factoryTempCoef(factoryTempCoef),
        .tempSensorValue(tempSensorValue),
        .presureAbnormality(presureAbnormality),
        .bloodAbnormality(bloodAbnormality),
        .fallDetected(fallDetected),
        .glycemicIndex(glycemicIndex),
        .temperatureAbnormality(temperatureAbnormality)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pack(input logic p, input logic b, input logic f,
                                        input logic [3:0] g, input logic t);
        return {p, b, f, g, t};
    endfunction

    function automatic logic [7:0] observed();
        return {presureAbnormality, bloodAbnormality, fallDetected, glycemicIndex, temperatureAbnormality};
    endfunction

    task automatic compare(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got pres=%b blood=%b fall=%b gi=%0d temp=%b, expected pres=%b blood=%b fall=%b gi=%0d temp=%b",
                     name, got[7], got[6], got[5], got[4:1], got[0],
                     want[7], want[6], want[5], want[4:1], want[0]);
        end
    endtask

    // Drive one vector between edges and queue its expected registered result.
    task automatic vec(input string name, input logic [5:0] pd, input logic [3:0] ph,
                       input logic [2:0] bt, input logic [7:0] fs, input logic [7:0] ff,
                       input logic [7:0] bs, input logic [7:0] base, input logic [3:0] coef,
                       input logic [3:0] ts, input logic [7:0] want);
        exp_t e;
        @(negedge clk);
        pressureData    = pd;
        bloodPH         = ph;
        bloodType       = bt;
        fdSensorValue   = fs;
        fdFactoryValue  = ff;
        bloodSensor     = bs;
        factoryBaseTemp = base;
        factoryTempCoef = coef;
        tempSensorValue = ts;
        e.name = name;
        e.val  = want;
        expQ.push_back(e);
    endtask

    // Monitor: one cycle after a vector is driven, its result is on the outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                compare(e.name, observed(), e.val);
            end
        end
    end

    initial begin
        int waitCycles;
        // reset held with non-trivial inputs
        rst = 1'b1;
        pressureData = 6'b100001; bloodPH = 4'd15; bloodType = 3'd1;
        fdSensorValue = 8'd200; fdFactoryValue = 8'd1; bloodSensor = 8'h00;
        factoryBaseTemp = 8'd0; factoryTempCoef = 4'd0; tempSensorValue = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        compare("reset_hold", observed(), 8'd0);
        @(negedge clk);
        rst = 1'b0;

        //    name          pd      ph     bt    fs      ff      bs          base    coef   ts     pres blood fall gi temp
        vec("vector_a",  6'd1,  4'd0,  3'd0, 8'd10,  8'd10,  8'b10000100, 8'd30,  4'd4,  4'd2,  pack(0, 1, 1, 4'd5, 1));
        vec("vector_b",  6'd33, 4'd8,  3'd1, 8'd9,   8'd10,  8'b11110100, 8'd35,  4'd4,  4'd2,  pack(1, 0, 0, 4'd2, 0));
        vec("neutral",   6'd0,  4'd8,  3'd0, 8'd0,   8'd1,   8'h7F,       8'd40,  4'd0,  4'd0,  pack(0, 0, 0, 4'd0, 0));
        vec("press_31",  6'd31, 4'd8,  3'd0, 8'd0,   8'd1,   8'h7F,       8'd40,  4'd0,  4'd0,  pack(0, 0, 0, 4'd0, 0));
        vec("press_32",  6'd32, 4'd8,  3'd0, 8'd0,   8'd1,   8'h7F,       8'd40,  4'd0,  4'd0,  pack(1, 0, 0, 4'd0, 0));
        vec("bt5_ph5",   6'd0,  4'd5,  3'd5, 8'd0,   8'd1,   8'h7F,       8'd40,  4'd0,  4'd0,  pack(0, 1, 0, 4'd0, 0));
        vec("bt5_ph6",   6'd0,  4'd6,  3'd5, 8'd0,   8'd1,   8'h7F,       8'd40,  4'd0,  4'd0,  pack(0, 0, 0, 4'd0, 0));
        vec("bt5_ph8",   6'd0,  4'd8,  3'd5, 8'd0,   8'd1,   8'h7F,       8'd40,  4'd0,  4'd0,  pack(0, 0, 0, 4'd0, 0));
        vec("bt5_ph9",   6'd0,  4'd9,  3'd5, 8'd0,   8'd1,   8'h7F,       8'd40,  4'd0,  4'd0,  pack(0, 1, 0, 4'd0, 0));
        vec("bt3_ph6",   6'd0,  4'd6,  3'd3, 8'd0,   8'd1,   8'h7F,       8'd40,  4'd0,  4'd0,  pack(0, 1, 0, 4'd0, 0));
        vec("bt3_ph9",   6'd0,  4'd9,  3'd3, 8'd0,   8'd1,   8'h7F,       8'd40,  4'd0,  4'd0,  pack(0, 0, 0, 4'd0, 0));
        vec("bt0_ph10",  6'd0,  4'd10, 3'd0, 8'd0,   8'd1,   8'h7F,       8'd40,  4'd0,  4'd0,  pack(0, 1, 0, 4'd0, 0));
        vec("fall_255",  6'd0,  4'd8,  3'd0, 8'd255, 8'd0,   8'h7F,       8'd40,  4'd0,  4'd0,  pack(0, 0, 1, 4'd0, 0));
        vec("fall_0v255",6'd0,  4'd8,  3'd0, 8'd0,   8'd255, 8'h7F,       8'd40,  4'd0,  4'd0,  pack(0, 0, 0, 4'd0, 0));
        vec("gi_00",     6'd0,  4'd8,  3'd0, 8'd0,   8'd1,   8'h00,       8'd40,  4'd0,  4'd0,  pack(0, 0, 0, 4'd7, 0));
        vec("gi_01",     6'd0,  4'd8,  3'd0, 8'd0,   8'd1,   8'h80,       8'd40,  4'd0,  4'd0,  pack(0, 0, 0, 4'd6, 0));
        vec("gi_3f",     6'd0,  4'd8,  3'd0, 8'd0,   8'd1,   8'h3F,       8'd40,  4'd0,  4'd0,  pack(0, 0, 0, 4'd1, 0));
        vec("gi_ff",     6'd0,  4'd8,  3'd0, 8'd0,   8'd1,   8'hFF,       8'd40,  4'd0,  4'd0,  pack(0, 0, 0, 4'd0, 0));
        vec("temp_480",  6'd0,  4'd8,  3'd0, 8'd0,   8'd1,   8'h7F,       8'd255, 4'd15, 4'd15, pack(0, 0, 0, 4'd0, 1));
        vec("temp_46",   6'd0,  4'd8,  3'd0, 8'd0,   8'd1,   8'h7F,       8'd45,  4'd1,  4'd1,  pack(0, 0, 0, 4'd0, 1));
        vec("temp_45",   6'd0,  4'd8,  3'd0, 8'd0,   8'd1,   8'h7F,       8'd45,  4'd0,  4'd7,  pack(0, 0, 0, 4'd0, 0));
        vec("temp_39",   6'd0,  4'd8,  3'd0, 8'd0,   8'd1,   8'h7F,       8'd39,  4'd0,  4'd0,  pack(0, 0, 0, 4'd0, 1));
        vec("temp_40mul",6'd0,  4'd8,  3'd0, 8'd0,   8'd1,   8'h7F,       8'd4,   4'd6,  4'd6,  pack(0, 0, 0, 4'd0, 0));
        vec("temp_wrap", 6'd0,  4'd8,  3'd0, 8'd0,   8'd1,   8'h7F,       8'd250, 4'd1,  4'd6,  pack(0, 0, 0, 4'd0, 1));
        vec("all_on",    6'd63, 4'd15, 3'd7, 8'd200, 8'd100, 8'h00,       8'd0,   4'd0,  4'd0,  pack(1, 1, 1, 4'd7, 1));

        // asynchronous reset mid-run: outputs clear before the next edge
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        compare("async_reset", observed(), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        vec("after_reset", 6'd1, 4'd0, 3'd0, 8'd10, 8'd10, 8'b10000100, 8'd30, 4'd4, 4'd2, pack(0, 1, 1, 4'd5, 1));

        waitCycles = 0;
        while (expQ.size() != 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        #2;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results never observed, expected 0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
